// File: rtl/platform_scheduler.sv
// Per-frame platform table sequencer: init placement, scroll, respawn via LFSR.
// Slots are updated one per cycle into a shadow table, then committed atomically.
module platform_scheduler #(
    parameter int unsigned H           = 480,
    parameter int unsigned X_MIN       = 140,
    parameter int unsigned X_MAX       = 499,
    parameter int unsigned PLAT_W      = 60,
    parameter int unsigned SCROLL_LINE = 200,
    parameter int unsigned MAX_SCROLL  = 8,
    parameter int unsigned INIT_STATE  = 0,
    parameter int unsigned PLAY_STATE  = 1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [1:0]  frame_clk_edge,
    input  logic [7:0]  state,
    input  logic [9:0]  player_y,
    output logic [9:0]  Platform_X_out [0:7],
    output logic [9:0]  Platform_Y_out [0:7],
    output logic [15:0] score,
    output logic        busy,
    output logic        overrun
);

    localparam logic [10:0] H_L     = 11'(H);
    localparam logic [9:0]  X_MIN_L = 10'(X_MIN);
    localparam logic [8:0]  SPAN_L  = 9'(X_MAX - PLAT_W - X_MIN + 1);
    localparam logic [9:0]  LINE_L  = 10'(SCROLL_LINE);
    localparam logic [9:0]  MAXS_L  = 10'(MAX_SCROLL);
    localparam logic [7:0]  INIT_L  = 8'(INIT_STATE);
    localparam logic [7:0]  PLAY_L  = 8'(PLAY_STATE);

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_SCAN, S_COMMIT} fsm_t;

    fsm_t        fsm;
    logic [2:0]  idx;
    logic [9:0]  scroll;
    logic [15:0] lfsr;
    logic        init_armed;
    logic        init_pass;
    logic [9:0]  sh_x [0:7];
    logic [9:0]  sh_y [0:7];

    logic        fb;
    logic [15:0] lfsr_adv;
    logic [8:0]  off;
    logic [9:0]  respawn_x;
    logic [9:0]  init_x;
    logic [9:0]  init_y;
    logic [10:0] sum_y;
    logic [9:0]  scroll_diff;
    logic [9:0]  scroll_calc;
    logic [16:0] score_sum;
    logic        frame_edge;

    always_comb begin
        fb        = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
        lfsr_adv  = {lfsr[14:0], fb};
        // Single conditional subtract folds the 9-bit value into the legal span.
        off       = lfsr_adv[8:0];
        if (off >= SPAN_L)
            off = off - SPAN_L;
        respawn_x = X_MIN_L + {1'b0, off};
        init_x    = X_MIN_L + 10'(idx) * 10'd40;
        init_y    = 10'(idx) * 10'd60;
        sum_y     = {1'b0, sh_y[idx]} + {1'b0, scroll};
        scroll_diff = LINE_L - player_y;
        scroll_calc = '0;
        if (player_y < LINE_L)
            scroll_calc = (scroll_diff > MAXS_L) ? MAXS_L : scroll_diff;
        score_sum  = {1'b0, score} + {7'b0, scroll};
        frame_edge = (frame_clk_edge == 2'b01);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fsm        <= S_IDLE;
            idx        <= '0;
            scroll     <= '0;
            lfsr       <= 16'hACE1;
            init_armed <= 1'b1;
            init_pass  <= 1'b0;
            score      <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                sh_x[i]           <= '0;
                sh_y[i]           <= '0;
                Platform_X_out[i] <= '0;
                Platform_Y_out[i] <= '0;
            end
        end else begin
            if (state != INIT_L)
                init_armed <= 1'b1;
            if (fsm != S_IDLE && frame_edge)
                overrun <= 1'b1;

            case (fsm)
                S_IDLE: begin
                    if (state == INIT_L && init_armed) begin
                        fsm       <= S_INIT;
                        idx       <= '0;
                        init_pass <= 1'b1;
                        busy      <= 1'b1;
                    end else if (frame_edge && state == PLAY_L) begin
                        scroll    <= scroll_calc;
                        fsm       <= S_SCAN;
                        idx       <= '0;
                        init_pass <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_INIT: begin
                    sh_x[idx] <= init_x;
                    sh_y[idx] <= init_y;
                    idx       <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        fsm        <= S_COMMIT;
                        init_armed <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (sum_y >= H_L) begin
                        sh_y[idx] <= 10'(sum_y - H_L);
                        sh_x[idx] <= respawn_x;
                        lfsr      <= lfsr_adv;
                    end else begin
                        sh_y[idx] <= sum_y[9:0];
                    end
                    idx <= idx + 3'd1;
                    if (idx == 3'd7)
                        fsm <= S_COMMIT;
                end
                S_COMMIT: begin
                    for (int unsigned i = 0; i < 8; i++) begin
                        Platform_X_out[i] <= sh_x[i];
                        Platform_Y_out[i] <= sh_y[i];
                    end
                    if (init_pass)
                        score <= '0;
                    else
                        score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    fsm  <= S_IDLE;
                    busy <= 1'b0;
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_platform_scheduler.sv
// Scoreboard bench for platform_scheduler: stimulus pushes expected tables, monitor checks each commit.
module tb_platform_scheduler;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [1:0]  frame_clk_edge = 2'b00;
    logic [7:0]  state = 8'd5;
    logic [9:0]  player_y = 10'd300;
    logic [9:0]  px [0:7];
    logic [9:0]  py [0:7];
    logic [15:0] score;
    logic        busy;
    logic        overrun;

    platform_scheduler dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk_edge(frame_clk_edge),
        .state(state), .player_y(player_y),
        .Platform_X_out(px), .Platform_Y_out(py),
        .score(score), .busy(busy), .overrun(overrun)
    );

    always #10 Clk = ~Clk;

    typedef struct packed {
        logic [7:0][9:0] x;
        logic [7:0][9:0] y;
        logic [15:0]     sc;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model of the committed table
    int          m_x [8];
    int          m_y [8];
    int          m_score;
    logic [15:0] m_lfsr;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin m_x[i] = 0; m_y[i] = 0; end
        m_score = 0;
        m_lfsr  = 16'hACE1;
    endtask

    task automatic model_init();
        for (int i = 0; i < 8; i++) begin m_x[i] = 140 + 40 * i; m_y[i] = 60 * i; end
        m_score = 0;
    endtask

    task automatic model_scan(input int s);
        int sum, off;
        for (int i = 0; i < 8; i++) begin
            sum = m_y[i] + s;
            if (sum >= 480) begin
                m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
                off = int'(m_lfsr[8:0]);
                if (off >= 300) off = off - 300;
                m_x[i] = 140 + off;
                m_y[i] = sum - 480;
            end else begin
                m_y[i] = sum;
            end
        end
        m_score = (m_score + s > 65535) ? 65535 : m_score + s;
    endtask

    task automatic push_exp();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.x[i] = 10'(m_x[i]);
            e.y[i] = 10'(m_y[i]);
        end
        e.sc = 16'(m_score);
        sb.push_back(e);
    endtask

    // Monitor: a busy falling edge means a commit just landed
    logic        prev_busy = 1'b0;
    int          busy_cnt = 0;
    logic        unstable = 1'b0;
    logic [9:0]  snap_x [0:7];
    logic [9:0]  snap_y [0:7];
    logic [15:0] snap_sc;

    always @(negedge Clk) begin
        if (!Reset_n) begin
            prev_busy = 1'b0;
            busy_cnt  = 0;
            unstable  = 1'b0;
        end else begin
            if (busy) begin
                if (!prev_busy) begin
                    for (int i = 0; i < 8; i++) begin snap_x[i] = px[i]; snap_y[i] = py[i]; end
                    snap_sc = score;
                end
                busy_cnt++;
                for (int i = 0; i < 8; i++)
                    if (px[i] != snap_x[i] || py[i] != snap_y[i]) unstable = 1'b1;
                if (score != snap_sc) unstable = 1'b1;
            end
            if (prev_busy && !busy) begin
                chk("busy_cycles", busy_cnt, 9);
                chk("stable_while_busy", int'(unstable), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_commit", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    for (int i = 0; i < 8; i++) begin
                        chk($sformatf("X[%0d]", i), int'(px[i]), int'(e.x[i]));
                        chk($sformatf("Y[%0d]", i), int'(py[i]), int'(e.y[i]));
                    end
                    chk("score", int'(score), int'(e.sc));
                end
                busy_cnt = 0;
                unstable = 1'b0;
            end
            prev_busy = busy;
        end
    end

    task automatic wait_done(input string nm);
        int n = 0;
        while ((busy || sb.size() != 0) && n < 60) begin
            @(negedge Clk);
            n++;
        end
        @(negedge Clk);
        chk({"done_", nm}, int'(n < 60), 1);
        @(posedge Clk); #1;
    endtask

    task automatic pulse_edge(input logic [9:0] y);
        @(posedge Clk); #1;
        player_y       = y;
        frame_clk_edge = 2'b01;
        @(posedge Clk); #1;
        frame_clk_edge = 2'b00;
    endtask

    task automatic frame(input logic [9:0] y, input int exp_scroll, input string nm);
        model_scan(exp_scroll);
        push_exp();
        pulse_edge(y);
        chk({"busy_rise_", nm}, int'(busy), 1);
        wait_done(nm);
    endtask

    task automatic do_init();
        model_init();
        push_exp();
        @(posedge Clk); #1;
        state = 8'd0;
        wait_done("init");
    endtask

    initial begin
        int seen;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_X0", int'(px[0]), 0);
        chk("rst_Y7", int'(py[7]), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        Reset_n = 1'b1;

        do_init();
        seen = 0;
        repeat (15) begin @(negedge Clk); if (busy) seen++; end
        chk("hold_init_no_rerun", seen, 0);

        state = 8'd1;
        frame(10'd300, 0, "scroll0");
        frame(10'd100, 8, "scroll8");
        chk("first_scroll_Y0", int'(py[0]), 8);
        chk("first_scroll_Y7", int'(py[7]), 428);
        for (int k = 0; k < 7; k++) frame(10'd100, 8, "scroll8_rep");
        chk("respawn_Y7", int'(py[7]), 4);
        chk("respawn_X7", int'(px[7]), 291);
        chk("keep_X6", int'(px[6]), 380);
        chk("score64", int'(score), 64);
        chk("no_overrun_yet", int'(overrun), 0);

        // Second edge three cycles into the scan is ignored but flagged
        model_scan(5);
        push_exp();
        pulse_edge(10'd195);
        repeat (2) @(posedge Clk);
        #1;
        frame_clk_edge = 2'b01;
        @(posedge Clk); #1;
        frame_clk_edge = 2'b00;
        wait_done("overlap");
        chk("overrun_set", int'(overrun), 1);

        frame(10'd199, 1, "scroll1");
        frame(10'd200, 0, "line_boundary");
        frame(10'd0, 8, "clamp_far");
        chk("overrun_sticky", int'(overrun), 1);

        state = 8'd2;
        pulse_edge(10'd100);
        chk("non_play_ignored", int'(busy), 0);
        state = 8'd1;

        // Reset in the middle of a scan: nothing committed, everything cleared
        pulse_edge(10'd100);
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("midrst_X7", int'(px[7]), 0);
        chk("midrst_Y3", int'(py[3]), 0);
        chk("midrst_score", int'(score), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_overrun", int'(overrun), 0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        model_reset();
        do_init();
        state = 8'd1;
        for (int k = 0; k < 8; k++) frame(10'd150, 8, "post_rst");
        chk("post_rst_X7_lfsr", int'(px[7]), 291);
        chk("post_rst_Y7", int'(py[7]), 4);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
